bm_dag3_out_fifo: RTL and testbench

- Downstream capture stage for the 2-bit DAG datapath.
- Accepts each DAG result word through a valid/ready handshake and buffers it in a small circular FIFO.
- Presents the words in order, show-ahead, to a downstream consumer.
- Keeps a running XOR signature of every accepted word so a bench or top level can check the DAG result stream without reading every word.

---
 rtl/bm_dag3_out_fifo_pkg.sv | 14 +
 rtl/bm_dag3_out_fifo_mem.sv | 26 ++
 rtl/bm_dag3_out_fifo.sv | 97 +++++++++
 tb/tb_bm_dag3_out_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bm_dag3_out_fifo_pkg.sv
// Shared defaults and occupancy encodings for the DAG output capture FIFO.
package bm_dag3_out_fifo_pkg;

  localparam int BITS_DEF      = 2;
  localparam int DEPTH_DEF     = 4;
  localparam int ADDR_BITS_DEF = 2;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_e;

endpackage : bm_dag3_out_fifo_pkg

// File: rtl/bm_dag3_out_fifo_mem.sv
// DEPTH x BITS register array: one synchronous write port, one asynchronous read port.
module bm_dag3_out_fifo_mem #(
  parameter int BITS      = 2,
  parameter int ADDR_BITS = 2
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [BITS-1:0]      wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [BITS-1:0]      rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [BITS-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; stale entries are never observed because the
  // top masks out_data while empty, and a reset here would cost a reset net per bit.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule : bm_dag3_out_fifo_mem

// File: rtl/bm_dag3_out_fifo.sv
// Show-ahead circular FIFO capturing DAG result words, with a running XOR signature.
module bm_dag3_out_fifo
  import bm_dag3_out_fifo_pkg::*;
#(
  parameter int BITS      = BITS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BITS-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BITS-1:0]      out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 sig_clear,
  output logic [ADDR_BITS:0]   count,
  output logic [BITS-1:0]      signature
);

  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(DEPTH);

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q,  count_d;
  logic [BITS-1:0]      sig_q,    sig_d;
  logic [BITS-1:0]      rd_word;
  logic                 push, pop;
  occ_e                 status;

  always_comb begin
    status = ST_PARTIAL;
    if (count_q == '0)      status = ST_EMPTY;
    else if (count_q == FULL_CNT) status = ST_FULL;
  end

  assign in_ready  = (status != ST_FULL);
  assign out_valid = (status != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sig_d    = sig_clear ? '0 : sig_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
      sig_d    = sig_d ^ in_data;
    end
    if (pop) rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
    if (push && !pop)      count_d = count_q + (ADDR_BITS+1)'(1);
    else if (pop && !push) count_d = count_q - (ADDR_BITS+1)'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sig_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sig_q    <= sig_d;
    end
  end

  bm_dag3_out_fifo_mem #(
    .BITS      (BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  assign out_data  = out_valid ? rd_word : '0;
  assign count     = count_q;
  assign signature = sig_q;

  // Occupancy may only step one status level per cycle.
  a_no_empty_to_full: assert property (
    @(posedge clock) disable iff (reset) (status == ST_EMPTY) |=> (status != ST_FULL));
  a_no_push_when_full: assert property (
    @(posedge clock) disable iff (reset) (status == ST_FULL) |-> !push);

endmodule : bm_dag3_out_fifo

// File: tb/tb_bm_dag3_out_fifo.sv
// Directed self-checking bench for bm_dag3_out_fifo with hand-computed expectations.
module tb_bm_dag3_out_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       sig_clear;
  logic [2:0] count;
  logic [1:0] signature;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] model_q[$];
  logic [1:0] model_sig;

  always #5 clock = ~clock;

  bm_dag3_out_fifo dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sig_clear (sig_clear),
    .count     (count),
    .signature (signature)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 2ns after the rising edge; outputs are sampled well before the next one.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    in_data   = 2'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sig_clear = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Reset then idle
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_in_ready",  8'(in_ready),  8'd1);
    check("rst_count",     8'(count),     8'd0);
    check("rst_signature", 8'(signature), 8'd0);
    check("rst_out_data",  8'(out_data),  8'd0);

    // out_ready on an empty FIFO must not move the read pointer
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("empty_pop_count", 8'(count), 8'd0);

    // Single push, no same-cycle bypass
    in_data = 2'd1; in_valid = 1'b1;
    #1;
    check("no_bypass_valid", 8'(out_valid), 8'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check("push1_valid", 8'(out_valid), 8'd1);
    check("push1_data",  8'(out_data),  8'd1);
    check("push1_count", 8'(count),     8'd1);
    check("push1_sig",   8'(signature), 8'd1);

    // Fill from empty with 3,2,1,0
    do_reset();
    in_valid = 1'b1;
    in_data = 2'd3; tick();
    in_data = 2'd2; tick();
    in_data = 2'd1; tick();
    #1;
    check("three_count",    8'(count),    8'd3);
    check("three_in_ready", 8'(in_ready), 8'd1);
    in_data = 2'd0; tick();
    #1;
    check("full_count",    8'(count),     8'd4);
    check("full_in_ready", 8'(in_ready),  8'd0);
    check("full_sig",      8'(signature), 8'd0);
    in_data = 2'd1; tick();
    #1;
    check("held_count", 8'(count),     8'd4);
    check("held_head",  8'(out_data),  8'd3);
    check("held_sig",   8'(signature), 8'd0);

    // Pop from full while in_valid is still high: no push that cycle
    out_ready = 1'b1;
    #1;
    check("fullpop_in_ready_pre", 8'(in_ready), 8'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("fullpop_count",    8'(count),     8'd3);
    check("fullpop_in_ready", 8'(in_ready),  8'd1);
    check("fullpop_head",     8'(out_data),  8'd2);
    check("fullpop_sig",      8'(signature), 8'd0);

    // Steady stream across pointer wrap, primed with one word
    do_reset();
    in_data = 2'd3; in_valid = 1'b1;
    tick();
    model_q = '{2'd3};
    model_sig = 2'd3;
    for (int i = 0; i < 10; i++) begin
      in_data = 2'(i % 4); in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check($sformatf("stream_head_%0d", i), 8'(out_data), 8'(model_q[0]));
      tick();
      void'(model_q.pop_front());
      model_q.push_back(2'(i % 4));
      model_sig ^= 2'(i % 4);
      check($sformatf("stream_count_%0d", i), 8'(count), 8'd1);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("stream_sig",  8'(signature), 8'(model_sig));
    check("stream_sig_const", 8'(signature), 8'd2);
    check("stream_tail", 8'(out_data),  8'd1);

    // Clear and push together: clear first, then fold in the new word
    sig_clear = 1'b1; in_valid = 1'b1; in_data = 2'd1;
    tick();
    sig_clear = 1'b0; in_valid = 1'b0;
    #1;
    check("clrpush_sig",   8'(signature), 8'd1);
    check("clrpush_count", 8'(count),     8'd2);
    sig_clear = 1'b1;
    tick();
    sig_clear = 1'b0;
    #1;
    check("clr_sig",   8'(signature), 8'd0);
    check("clr_count", 8'(count),     8'd2);
    check("clr_head",  8'(out_data),  8'd1);

    // Asynchronous reset mid-cycle with two words buffered
    reset = 1'b1;
    #1;
    check("async_rst_count", 8'(count),     8'd0);
    check("async_rst_valid", 8'(out_valid), 8'd0);
    check("async_rst_data",  8'(out_data),  8'd0);
    #2;
    reset = 1'b0;
    tick();
    sig_clear = 1'b1; in_valid = 1'b1; in_data = 2'd2;
    tick();
    sig_clear = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_sig",   8'(signature), 8'd2);
    check("post_rst_count", 8'(count),     8'd1);
    check("post_rst_head",  8'(out_data),  8'd2);

    // Drain to empty: out_data forced to zero, signature unaffected by pops
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("drain_count", 8'(count),     8'd0);
    check("drain_valid", 8'(out_valid), 8'd0);
    check("drain_data",  8'(out_data),  8'd0);
    check("drain_sig",   8'(signature), 8'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_bm_dag3_out_fifo
